battle_datapath: RTL

//  Datapath for the battle control FSM. Holds both Pokemon's HP, per-move PP

---
 rtl/battle_datapath.sv | 121 ++++++++++++
 1 files changed

// File: rtl/battle_datapath.sv
//------------------------------------------------------------------------------
// Module      : battle_datapath
// Description : HP, per-move PP and LFSR-driven AI move datapath for the battle
//               control FSM. Define CRIT_EN to enable LFSR-driven critical hits.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module battle_datapath #(
    parameter int           HP_W      = 4,
    parameter int           HP_MAX    = 15,
    parameter int           PP_W      = 2,
    parameter int           PP_INIT   = 3,
    parameter int           STRUGGLE  = 1,
    parameter logic [7:0]   LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            calc_damage,
    input  logic            apply_damage,
    input  logic            active_trainer,
    input  logic            target,
    input  logic [1:0]      p_move_sel,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic            p_fainted,
    output logic            ai_fainted,
    output logic [HP_W-1:0] dmg_out,
    output logic            dmg_valid,
    output logic            crit,
    output logic [1:0]      ai_move,
    output logic [PP_W-1:0] p_pp_left
);

    // An all-zero seed would lock the LFSR up forever.
    localparam logic [7:0] C_SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [7:0]      r_lfsr;
    logic [HP_W-1:0] r_hp [2];
    logic [PP_W-1:0] r_pp [2][4];
    logic [HP_W-1:0] r_dmg;
    logic            r_valid;
    logic            r_crit;
    logic [1:0]      r_ai_move;

    logic [1:0]      w_mv;
    logic            w_pp_avail;
    logic [HP_W-1:0] w_base;
    logic [HP_W-1:0] w_dmg;
    logic            w_crit;
    logic            w_fb;
    logic [HP_W-1:0] w_hp_tgt;
    logic [HP_W-1:0] w_hp_new;

    assign w_fb       = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_mv       = active_trainer ? r_lfsr[1:0] : p_move_sel;
    assign w_pp_avail = (r_pp[active_trainer][w_mv] != '0);
    assign w_base     = w_pp_avail ? (HP_W'(w_mv) + HP_W'(1)) : HP_W'(STRUGGLE);

`ifdef CRIT_EN
    logic [HP_W:0] w_dbl;
    assign w_crit = (r_lfsr[7:5] == 3'b111);
    assign w_dbl  = {w_base, 1'b0};
    // Doubled damage is even, so it fits unless the carry-out bit is set.
    assign w_dmg  = !w_crit ? w_base : (w_dbl[HP_W] ? '1 : w_dbl[HP_W-1:0]);
`else
    assign w_crit = 1'b0;
    assign w_dmg  = w_base;
`endif

    assign w_hp_tgt = r_hp[target];
    assign w_hp_new = (w_hp_tgt < r_dmg) ? '0 : (w_hp_tgt - r_dmg);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr    <= C_SEED;
            r_hp[0]   <= HP_W'(HP_MAX);
            r_hp[1]   <= HP_W'(HP_MAX);
            for (int t = 0; t < 2; t++) begin
                for (int m = 0; m < 4; m++) begin
                    r_pp[t][m] <= PP_W'(PP_INIT);
                end
            end
            r_dmg     <= '0;
            r_valid   <= 1'b0;
            r_crit    <= 1'b0;
            r_ai_move <= 2'd0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            if (apply_damage && r_valid) begin
                r_hp[target] <= w_hp_new;
                r_valid      <= 1'b0;
            end
            // A same-cycle calc wins over the apply's clear of the valid flag.
            if (calc_damage) begin
                if (w_pp_avail) begin
                    r_pp[active_trainer][w_mv] <= r_pp[active_trainer][w_mv] - PP_W'(1);
                end
                r_dmg   <= w_dmg;
                r_valid <= 1'b1;
                r_crit  <= w_crit;
                if (active_trainer) begin
                    r_ai_move <= w_mv;
                end
            end
        end
    end

    assign p_hp       = r_hp[0];
    assign ai_hp      = r_hp[1];
    assign p_fainted  = (r_hp[0] == '0);
    assign ai_fainted = (r_hp[1] == '0);
    assign dmg_out    = r_dmg;
    assign dmg_valid  = r_valid;
    assign crit       = r_crit;
    assign ai_move    = r_ai_move;
    assign p_pp_left  = r_pp[0][p_move_sel];

endmodule

`default_nettype wire
